// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter and its per-source FIFOs.
package cdb_arbiter_pkg;

  localparam int CDB_ROB_WIDTH  = 4;
  localparam int CDB_FIFO_DEPTH = 4;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

endpackage

// File: rtl/cdb_fifo.sv
// Circular-buffer FIFO with a free-running power-of-two pointer pair and an occupancy count.
module cdb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == FULL_COUNT);
  assign empty     = (count_r == {(AW + 1){1'b0}});
  assign head_data = mem_r[head_r];
  assign push_ok_s = en && !flush && push && !full;
  assign pop_ok_s  = en && !flush && pop && !empty;

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[tail_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {(AW + 1){1'b0}};
    end else if (en && flush) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {(AW + 1){1'b0}};
    end else begin
      if (push_ok_s) begin
        tail_r <= tail_r + 1'b1;
      end
      if (pop_ok_s) begin
        head_r <= head_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB broadcast between the ALU path and the load/store buffer.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_WIDTH  = CDB_ROB_WIDTH,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ROB_WIDTH-1:0] alu_rob_id,
  input  logic [31:0]          alu_data,
  input  logic                 alu_set_jump_addr,
  input  logic                 lsb_valid,
  output logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_data,
  output logic                 cdb_en,
  output logic [ROB_WIDTH-1:0] cdb_rob_id,
  output logic [31:0]          cdb_data,
  output logic                 cdb_set_jump_addr,
  output logic                 cdb_src
);

  localparam int ALU_W = ROB_WIDTH + 33;
  localparam int LSB_W = ROB_WIDTH + 32;

  logic             alu_full, alu_empty, lsb_full, lsb_empty;
  logic [ALU_W-1:0] alu_head;
  logic [LSB_W-1:0] lsb_head;
  logic             grant_valid, grant_src;
  logic             alu_pop, lsb_pop;
  logic             last_grant;
  logic [ROB_WIDTH-1:0] sel_rob_id;
  logic [31:0]          sel_data;
  logic                 sel_jump;

  assign alu_ready = !alu_full;
  assign lsb_ready = !lsb_full;
  assign alu_pop   = grant_valid && (grant_src == CDB_SRC_ALU);
  assign lsb_pop   = grant_valid && (grant_src == CDB_SRC_LSB);

  cdb_fifo #(.WIDTH(ALU_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .en        (rdy_in),
    .flush     (flush),
    .push      (alu_valid),
    .pop       (alu_pop),
    .push_data ({alu_set_jump_addr, alu_rob_id, alu_data}),
    .full      (alu_full),
    .empty     (alu_empty),
    .head_data (alu_head)
  );

  cdb_fifo #(.WIDTH(LSB_W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .en        (rdy_in),
    .flush     (flush),
    .push      (lsb_valid),
    .pop       (lsb_pop),
    .push_data ({lsb_rob_id, lsb_data}),
    .full      (lsb_full),
    .empty     (lsb_empty),
    .head_data (lsb_head)
  );

  // Grant from occupancy at cycle start; on a tie the source that did not win last time goes.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = CDB_SRC_ALU;
    if (!alu_empty && !lsb_empty) begin
      grant_valid = 1'b1;
      grant_src   = ~last_grant;
    end else if (!alu_empty) begin
      grant_valid = 1'b1;
      grant_src   = CDB_SRC_ALU;
    end else if (!lsb_empty) begin
      grant_valid = 1'b1;
      grant_src   = CDB_SRC_LSB;
    end else begin
      grant_valid = 1'b0;
      grant_src   = CDB_SRC_ALU;
    end
  end

  // Select the granted head; LSB results never carry a jump target.
  always_comb begin
    if (grant_src == CDB_SRC_LSB) begin
      sel_rob_id = lsb_head[LSB_W-1:32];
      sel_data   = lsb_head[31:0];
      sel_jump   = 1'b0;
    end else begin
      sel_rob_id = alu_head[ALU_W-2:32];
      sel_data   = alu_head[31:0];
      sel_jump   = alu_head[ALU_W-1];
    end
  end

  // Broadcast registers and round-robin history.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_en            <= 1'b0;
      cdb_rob_id        <= {ROB_WIDTH{1'b0}};
      cdb_data          <= 32'h0000_0000;
      cdb_set_jump_addr <= 1'b0;
      cdb_src           <= CDB_SRC_ALU;
      last_grant        <= CDB_SRC_LSB;
    end else if (!rdy_in) begin
      cdb_en     <= cdb_en;
      last_grant <= last_grant;
    end else if (flush) begin
      cdb_en     <= 1'b0;
      last_grant <= CDB_SRC_LSB;
    end else if (grant_valid) begin
      cdb_en            <= 1'b1;
      cdb_rob_id        <= sel_rob_id;
      cdb_data          <= sel_data;
      cdb_set_jump_addr <= sel_jump;
      cdb_src           <= grant_src;
      last_grant        <= grant_src;
    end else begin
      cdb_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: latency, tie-breaking, back-pressure, flush, stall and reset.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        flush;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_rob_id;
  logic [31:0] alu_data;
  logic        alu_set_jump_addr;
  logic        lsb_valid;
  logic        lsb_ready;
  logic [3:0]  lsb_rob_id;
  logic [31:0] lsb_data;
  logic        cdb_en;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_data;
  logic        cdb_set_jump_addr;
  logic        cdb_src;

  int n_checks = 0;
  int n_pass   = 0;
  logic [36:0] bq[$];

  cdb_arbiter dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .rdy_in            (rdy_in),
    .flush             (flush),
    .alu_valid         (alu_valid),
    .alu_ready         (alu_ready),
    .alu_rob_id        (alu_rob_id),
    .alu_data          (alu_data),
    .alu_set_jump_addr (alu_set_jump_addr),
    .lsb_valid         (lsb_valid),
    .lsb_ready         (lsb_ready),
    .lsb_rob_id        (lsb_rob_id),
    .lsb_data          (lsb_data),
    .cdb_en            (cdb_en),
    .cdb_rob_id        (cdb_rob_id),
    .cdb_data          (cdb_data),
    .cdb_set_jump_addr (cdb_set_jump_addr),
    .cdb_src           (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock edge, then sample 1 ns later and log any broadcast.
  task automatic cycle();
    @(posedge clk_in);
    #1;
    if (cdb_en) bq.push_back({cdb_src, cdb_rob_id, cdb_data});
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rob_id = 4'd0; alu_data = 32'd0; alu_set_jump_addr = 1'b0;
    lsb_valid = 1'b0; lsb_rob_id = 4'd0; lsb_data = 32'd0;
    flush = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n_in = 1'b0;
    cycle();
    cycle();
    rst_n_in = 1'b1;
    cycle();
    bq.delete();
  endtask

  task automatic check_bcast(input string tag, input logic src, input logic [3:0] rob);
    check_eq({tag, "_en"}, 64'(cdb_en), 64'd1);
    check_eq({tag, "_src"}, 64'(cdb_src), 64'(src));
    check_eq({tag, "_rob"}, 64'(cdb_rob_id), 64'(rob));
  endtask

  initial begin
    int l_tag, a_tag, l_exp, a_exp;
    logic acc_l, acc_a;

    // Test 1: single ALU result latency
    do_reset();
    check_eq("rst_en", 64'(cdb_en), 64'd0);
    check_eq("rst_alu_rdy", 64'(alu_ready), 64'd1);
    check_eq("rst_lsb_rdy", 64'(lsb_ready), 64'd1);
    alu_valid = 1'b1; alu_rob_id = 4'd3; alu_data = 32'h0000_00AA; alu_set_jump_addr = 1'b1;
    cycle();
    idle_inputs();
    check_eq("t1_no_bypass", 64'(cdb_en), 64'd0);
    cycle();
    check_bcast("t1", 1'b0, 4'd3);
    check_eq("t1_data", 64'(cdb_data), 64'h0000_00AA);
    check_eq("t1_jump", 64'(cdb_set_jump_addr), 64'd1);
    cycle();
    check_eq("t1_en_drop", 64'(cdb_en), 64'd0);

    // Test 2: simultaneous arrival, ALU wins the first tie
    do_reset();
    alu_valid = 1'b1; alu_rob_id = 4'd1; alu_data = 32'h11; alu_set_jump_addr = 1'b1;
    lsb_valid = 1'b1; lsb_rob_id = 4'd2; lsb_data = 32'h22;
    cycle();
    idle_inputs();
    cycle();
    check_bcast("t2_first", 1'b0, 4'd1);
    cycle();
    check_bcast("t2_second", 1'b1, 4'd2);
    check_eq("t2_lsb_jump", 64'(cdb_set_jump_addr), 64'd0);
    check_eq("t2_data", 64'(cdb_data), 64'h22);

    // Test 3: both sources streaming, LSB back-pressure and ordering across wrap
    do_reset();
    l_tag = 0; a_tag = 0;
    for (int c = 0; c < 40; c++) begin
      lsb_valid = (l_tag < 8); lsb_rob_id = l_tag[3:0]; lsb_data = 32'h100 + l_tag;
      alu_valid = (a_tag < 8); alu_rob_id = a_tag[3:0]; alu_data = 32'h200 + a_tag;
      acc_l = lsb_valid && lsb_ready;
      acc_a = alu_valid && alu_ready;
      cycle();
      if (acc_l) l_tag++;
      if (acc_a) a_tag++;
      if (c == 4) check_eq("t3_lsb_rdy_e4", 64'(lsb_ready), 64'd1);
      if (c == 5) check_eq("t3_lsb_rdy_e5", 64'(lsb_ready), 64'd0);
    end
    idle_inputs();
    check_eq("t3_total", 64'(bq.size()), 64'd16);
    l_exp = 0; a_exp = 0;
    foreach (bq[i]) begin
      if (i < 8) check_eq($sformatf("t3_alt%0d", i), 64'(bq[i][36]), 64'(i % 2));
      if (bq[i][36]) begin
        check_eq($sformatf("t3_lsb_rob%0d", l_exp), 64'(bq[i][35:32]), 64'(l_exp));
        check_eq($sformatf("t3_lsb_data%0d", l_exp), 64'(bq[i][31:0]), 64'(32'h100 + l_exp));
        l_exp++;
      end else begin
        check_eq($sformatf("t3_alu_rob%0d", a_exp), 64'(bq[i][35:32]), 64'(a_exp));
        a_exp++;
      end
    end
    check_eq("t3_lsb_count", 64'(l_exp), 64'd8);

    // Test 4: flush drops everything pending and that cycle's inputs
    do_reset();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_rob_id = 4'(c + 8); alu_data = 32'h300 + c;
      lsb_valid = 1'b1; lsb_rob_id = 4'(c + 12); lsb_data = 32'h400 + c;
      cycle();
    end
    flush = 1'b1;
    cycle();
    idle_inputs();
    check_eq("t4_en", 64'(cdb_en), 64'd0);
    check_eq("t4_alu_rdy", 64'(alu_ready), 64'd1);
    check_eq("t4_lsb_rdy", 64'(lsb_ready), 64'd1);
    bq.delete();
    repeat (6) cycle();
    check_eq("t4_no_stale", 64'(bq.size()), 64'd0);

    // Test 5: rdy_in low freezes a live broadcast
    do_reset();
    alu_valid = 1'b1; alu_rob_id = 4'd4; alu_data = 32'h44;
    lsb_valid = 1'b1; lsb_rob_id = 4'd12; lsb_data = 32'hC0;
    cycle();
    alu_rob_id = 4'd5; alu_data = 32'h55;
    lsb_rob_id = 4'd13; lsb_data = 32'hD0;
    cycle();
    check_bcast("t5_pre", 1'b0, 4'd4);
    idle_inputs();
    rdy_in = 1'b0;
    alu_valid = 1'b1; alu_rob_id = 4'd9;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check_bcast($sformatf("t5_hold%0d", c), 1'b0, 4'd4);
    end
    idle_inputs();
    cycle();
    check_bcast("t5_r1", 1'b1, 4'd12);
    cycle();
    check_bcast("t5_r2", 1'b0, 4'd5);
    cycle();
    check_bcast("t5_r3", 1'b1, 4'd13);
    cycle();
    check_eq("t5_done", 64'(cdb_en), 64'd0);

    // Test 6: asynchronous reset mid-stream
    do_reset();
    alu_valid = 1'b1; alu_rob_id = 4'd2; alu_data = 32'h66;
    lsb_valid = 1'b1; lsb_rob_id = 4'd3; lsb_data = 32'h77;
    cycle();
    cycle();
    cycle();
    #2;
    rst_n_in = 1'b0;
    #1;
    check_eq("t6_en_clr", 64'(cdb_en), 64'd0);
    check_eq("t6_alu_rdy", 64'(alu_ready), 64'd1);
    check_eq("t6_lsb_rdy", 64'(lsb_ready), 64'd1);
    idle_inputs();
    cycle();
    rst_n_in = 1'b1;
    cycle();
    check_eq("t6_idle", 64'(cdb_en), 64'd0);
    alu_valid = 1'b1; alu_rob_id = 4'd6; alu_data = 32'h88;
    lsb_valid = 1'b1; lsb_rob_id = 4'd7; lsb_data = 32'h99;
    cycle();
    idle_inputs();
    cycle();
    check_bcast("t6_first", 1'b0, 4'd6);
    cycle();
    check_bcast("t6_second", 1'b1, 4'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between two result producers: the ALU path of the reservation station and the load/store buffer.
- Buffers each producer's results in a small per-source FIFO, with back-pressure.
- Grants the bus round-robin and drives one registered broadcast per cycle to the reorder buffer, reservation station and load/store buffer.
- Producers no longer need separate broadcast ports at every consumer.

Parameters:
ROB_WIDTH, 4, width of a reorder-buffer tag
FIFO_DEPTH, 4, entries per source FIFO (power of two, >= 2)

Ports:
clk_in  input  1  clock
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global enable; low freezes all state
flush  input  1  misprediction flush, qualified by rdy_in
alu_valid  input  1  ALU result present
alu_ready  output  1  ALU FIFO can accept
alu_rob_id  input  ROB_WIDTH  ALU result tag
alu_data  input  32  ALU result value
alu_set_jump_addr  input  1  result is a jump target
lsb_valid  input  1  LSB result present
lsb_ready  output  1  LSB FIFO can accept
lsb_rob_id  input  ROB_WIDTH  LSB result tag
lsb_data  input  32  LSB result value
cdb_en  output  1  broadcast valid this cycle
cdb_rob_id  output  ROB_WIDTH  broadcast tag
cdb_data  output  32  broadcast value
cdb_set_jump_addr  output  1  jump flag (always 0 for LSB entries)
cdb_src  output  1  0 = ALU, 1 = LSB

Behaviour:
Reset and enable:
- Reset (rst_n_in low, asynchronous) clears: both FIFOs, all cdb_* outputs, last_grant = 1 (LSB), so the ALU wins the first tie.
- When rdy_in = 0: no enqueue, no dequeue, cdb_* outputs hold, last_grant holds.

Enqueue:
- ready = !full. Ready does not look ahead at a same-cycle pop, so a full FIFO refuses input even in a cycle it dequeues.
- Enqueue happens on rising edge when valid && ready && rdy_in && !flush.
- LSB entries store set_jump_addr = 0.

Grant (combinational from FIFO occupancy at cycle start):
- Only ALU FIFO non-empty: grant ALU.
- Only LSB FIFO non-empty: grant LSB.
- Both non-empty: grant the source != last_grant.
- Neither non-empty: no grant.

Dequeue and broadcast:
- On the edge, the granted head is popped and loaded into the cdb_* registers; cdb_en = 1 for exactly one cycle; last_grant = granted source.
- With no grant, cdb_en = 0 and the other cdb_* fields hold their old values.

Latency:
- Enqueue at edge E means cdb_en is high after edge E+1 at the earliest.
- A newly enqueued entry is never popped at the same edge (no bypass).

Throughput:
- One broadcast per cycle.
- With both sources continuously busy, the bus alternates strictly between them.

FIFO details:
- Circular buffer: head/tail pointers of log2(FIFO_DEPTH) bits that wrap naturally, plus a count of log2(FIFO_DEPTH)+1 bits.
- Push and pop in the same cycle leave the count unchanged.
- Entries leave in order within each source.

Flush (flush && rdy_in):
- Synchronously empties both FIFOs, forces cdb_en = 0 next cycle, sets last_grant = 1.
- Drops that cycle's inputs.
- Takes priority over enqueue and dequeue.

Other conditions:
- Reset mid-operation discards all buffered results immediately.
- No tag checking or duplicate filtering; producers guarantee unique tags.

Decomposition:
- Shared package/header: ROB_WIDTH, CDB_SRC_ALU = 0, CDB_SRC_LSB = 1, CDB_FIFO_DEPTH default.
- One sub-module, cdb_fifo, parameterised by data width and depth, with push/pop/flush, full/empty and head data. It is instantiated twice: 37-bit payload for the ALU, 36-bit for the LSB. The arbiter top holds the grant logic, last_grant and output registers.

Test Plan:
1. Reset, then a single ALU result (rob_id 3, data 0x0000_00AA, jump 1) at edge E → cdb_en = 1 only after E+1, with rob_id 3, data 0xAA, set_jump_addr 1, src 0; cdb_en = 0 after E+2.
2. ALU and LSB valid in the same cycle (tags 1 and 2) from reset → broadcasts in order tag 1 (src 0), then tag 2 (src 1), on consecutive cycles.
3. LSB held valid with FIFO_DEPTH = 4 while the ALU FIFO keeps the bus alternating → lsb_ready drops after 4 unbroadcast entries; no entry is lost or reordered; tags leave the LSB FIFO in issue order 0..7 across pointer wrap.
4. Both FIFOs loaded with 3 entries, flush && rdy_in asserted → next cycle cdb_en = 0, both readies = 1, and no stale tag is broadcast afterwards.
5. rdy_in held low for 3 cycles with entries pending and cdb_en = 1 → outputs frozen with the same tag, no pops; normal alternation resumes when rdy_in returns high.
6. Assert rst_n_in low asynchronously between clock edges during streaming → cdb_en and readies clear immediately; the first result after release is ALU-first on a tie.
